// File: rtl/nested_fsm_pkg.sv
// Shared types and output codes for the nested colour controller.
// Imported by nested_color_fsm and hsv_child_fsm.
package nested_fsm_pkg;

  typedef enum logic [1:0] {
    P_BLUE = 2'd0,
    P_RED  = 2'd1,
    P_HSV  = 2'd2
  } parent_state_t;

  typedef enum logic [1:0] {
    C_H = 2'd0,
    C_S = 2'd1,
    C_V = 2'd2
  } child_state_t;

  typedef enum logic [1:0] {
    CMD_NONE      = 2'd0,
    CMD_TOGGLE    = 2'd1,
    CMD_ENTER_HSV = 2'd2,
    CMD_ABORT     = 2'd3
  } cmd_t;

  localparam logic [2:0] OUT_BLUE = 3'd1;
  localparam logic [2:0] OUT_RED  = 3'd2;
  localparam logic [2:0] OUT_H    = 3'd4;
  localparam logic [2:0] OUT_S    = 3'd5;
  localparam logic [2:0] OUT_V    = 3'd6;

endpackage

// File: rtl/hsv_child_fsm.sv
// Child sequencer for the HSV parent state: steps H -> S -> V, dwelling
// DWELL_CYCLES cycles in each; finish is high during the last V cycle.
module hsv_child_fsm
  import nested_fsm_pkg::*;
#(
  parameter int DWELL_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output child_state_t sub_state,
  output logic         finish
);

  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  child_state_t   sub_next;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_next;
  logic           running;
  logic           running_next;
  logic           last;

  assign last   = (cnt == CW'(DWELL_CYCLES - 1));
  assign finish = running && (sub_state == C_V) && last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_state <= C_H;
      cnt       <= '0;
      running   <= 1'b0;
    end else begin
      sub_state <= sub_next;
      cnt       <= cnt_next;
      running   <= running_next;
    end
  end

  // Idle (not running) parks the child at H with a cleared counter.
  always_comb begin
    sub_next     = sub_state;
    cnt_next     = cnt;
    running_next = running;
    if (abort) begin
      sub_next     = C_H;
      cnt_next     = '0;
      running_next = 1'b0;
    end else if (start) begin
      sub_next     = C_H;
      cnt_next     = '0;
      running_next = 1'b1;
    end else if (running) begin
      if (last) begin
        cnt_next = '0;
        case (sub_state)
          C_H: sub_next = C_S;
          C_S: sub_next = C_V;
          default: begin
            sub_next     = C_H;
            running_next = 1'b0;
          end
        endcase
      end else begin
        cnt_next = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nested_color_fsm.sv
// Two-level colour controller: parent BLUE/RED/HSV with a timed H/S/V child.
// Define NESTED_FSM_ABORT_EN to let ABORT cut an HSV sequence short.
module nested_color_fsm
  import nested_fsm_pkg::*;
#(
  parameter int IN_WIDTH     = 2,
  parameter int OUT_WIDTH    = 4,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 busy,
  output logic                 done
);

  parent_state_t parent;
  parent_state_t parent_next;
  child_state_t  sub_state;
  cmd_t          cmd;
  logic          start;
  logic          abort_req;
  logic          child_finish;

  // Invalid or out-of-range commands collapse to NONE.
  always_comb begin
    cmd = CMD_NONE;
    if (in_valid && ((in >> 2) == '0))
      cmd = cmd_t'(in[1:0]);
  end

  assign start = (parent == P_RED) && (cmd == CMD_ENTER_HSV);

`ifdef NESTED_FSM_ABORT_EN
  assign abort_req = (parent == P_HSV) && (cmd == CMD_ABORT);
`else
  assign abort_req = 1'b0;
`endif

  hsv_child_fsm #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_child (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort_req),
    .sub_state (sub_state),
    .finish    (child_finish)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parent <= P_RED;
      done   <= 1'b0;
    end else begin
      parent <= parent_next;
      done   <= child_finish && !abort_req;
    end
  end

  always_comb begin
    parent_next = parent;
    case (parent)
      P_BLUE: if (cmd == CMD_TOGGLE) parent_next = P_RED;
      P_RED: begin
        if (cmd == CMD_TOGGLE)         parent_next = P_BLUE;
        else if (cmd == CMD_ENTER_HSV) parent_next = P_HSV;
      end
      P_HSV: if (abort_req || child_finish) parent_next = P_RED;
      default: parent_next = P_RED;
    endcase
  end

  always_comb begin
    out = '0;
    case (parent)
      P_BLUE: out[2:0] = OUT_BLUE;
      P_RED:  out[2:0] = OUT_RED;
      P_HSV: begin
        case (sub_state)
          C_H:     out[2:0] = OUT_H;
          C_S:     out[2:0] = OUT_S;
          C_V:     out[2:0] = OUT_V;
          default: out[2:0] = OUT_RED;
        endcase
      end
      default: out[2:0] = OUT_RED;
    endcase
  end

  assign busy = (parent == P_HSV);

endmodule

// File: tb/tb_nested_color_fsm.sv
// Randomised self-checking bench for nested_color_fsm; two instances
// (DWELL_CYCLES=4 with IN_WIDTH=4, and DWELL_CYCLES=1) against a cycle model.
module tb_nested_color_fsm;

  localparam int M_BLUE = 0;
  localparam int M_RED  = 1;
  localparam int M_HSV  = 2;
`ifdef NESTED_FSM_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid0 = 1'b0;
  logic [3:0] in0 = '0;
  logic [3:0] out0;
  logic       busy0, done0;
  logic       in_valid1 = 1'b0;
  logic [1:0] in1 = '0;
  logic [2:0] out1;
  logic       busy1, done1;

  int total = 0;
  int bad   = 0;

  int m_mode[2] = '{M_RED, M_RED};
  int m_t[2]    = '{0, 0};
  bit m_done[2] = '{1'b0, 1'b0};
  int dw[2]     = '{4, 1};

  always #5 clk = ~clk;

  nested_color_fsm #(.IN_WIDTH(4), .OUT_WIDTH(4), .DWELL_CYCLES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in(in0),
    .out(out0), .busy(busy0), .done(done0)
  );

  nested_color_fsm #(.IN_WIDTH(2), .OUT_WIDTH(3), .DWELL_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in(in1),
    .out(out1), .busy(busy1), .done(done1)
  );

  // Reference model: HSV tracked as elapsed cycles, colour derived by division.
  function automatic int decode(input logic v, input logic [3:0] val);
    if (!v || val[3:2] != 2'b00) return 0;
    return int'(val[1:0]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_RED;
      m_t[k]    = 0;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input int cmd);
    m_done[k] = 1'b0;
    case (m_mode[k])
      M_BLUE: if (cmd == 1) m_mode[k] = M_RED;
      M_RED: begin
        if (cmd == 1) m_mode[k] = M_BLUE;
        else if (cmd == 2) begin
          m_mode[k] = M_HSV;
          m_t[k]    = 0;
        end
      end
      default: begin
        if (ABORT_EN && cmd == 3) begin
          m_mode[k] = M_RED;
        end else if (m_t[k] == 3 * dw[k] - 1) begin
          m_mode[k] = M_RED;
          m_done[k] = 1'b1;
        end else begin
          m_t[k]++;
        end
      end
    endcase
  endtask

  function automatic int exp_code(input int k);
    case (m_mode[k])
      M_BLUE:  return 1;
      M_RED:   return 2;
      default: return 4 + m_t[k] / dw[k];
    endcase
  endfunction

  function automatic logic [5:0] exp0();
    return {4'(exp_code(0)), m_mode[0] == M_HSV, m_done[0]};
  endfunction

  function automatic logic [4:0] exp1();
    return {3'(exp_code(1)), m_mode[1] == M_HSV, m_done[1]};
  endfunction

  task automatic drive_cycle(input logic v0, input logic [3:0] i0,
                             input logic v1, input logic [1:0] i1);
    in_valid0 = v0; in0 = i0;
    in_valid1 = v1; in1 = i1;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0, decode(v0, i0));
      model_step(1, decode(v1, {2'b00, i1}));
    end
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    total++;
    if ({out0, busy0, done0} !== 6'b0010_0_0) begin
      bad++; $display("[TB] FAIL reset_immediate d0 got=%b exp=%b", {out0, busy0, done0}, 6'b0010_0_0);
    end
    total++;
    if ({out1, busy1, done1} !== 5'b010_0_0) begin
      bad++; $display("[TB] FAIL reset_immediate d1 got=%b exp=%b", {out1, busy1, done1}, 5'b010_0_0);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 4'd1, 1'b1, 2'd2);
      total++;
      if ({out0, busy0, done0} !== exp0()) begin
        bad++; $display("[TB] FAIL reset_hold d0 got=%b exp=%b", {out0, busy0, done0}, exp0());
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b0, 4'd0, 1'b0, 2'd0);
    total++;
    if ({out1, busy1, done1} !== exp1()) begin
      bad++; $display("[TB] FAIL reset_release d1 got=%b exp=%b", {out1, busy1, done1}, exp1());
    end
  endtask

  task automatic test_toggle();
    logic       v[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] c[4] = '{4'd1, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(v[i], c[i], v[i], c[i][1:0]);
      total++;
      if ({out0, busy0, done0} !== exp0()) begin
        bad++; $display("[TB] FAIL toggle[%0d] d0 got=%b exp=%b", i, {out0, busy0, done0}, exp0());
      end
      total++;
      if ({out1, busy1, done1} !== exp1()) begin
        bad++; $display("[TB] FAIL toggle[%0d] d1 got=%b exp=%b", i, {out1, busy1, done1}, exp1());
      end
    end
  endtask

  task automatic test_wide_ignore();
    drive_cycle(1'b1, 4'b0101, 1'b0, 2'd0);
    total++;
    if (out0 !== 4'd2 || out0 !== 4'(exp_code(0))) begin
      bad++; $display("[TB] FAIL wide_ignore got=%0d exp=2", out0);
    end
  endtask

  task automatic test_hsv_sequence();
    int busy_cnt = 0;
    int done_cnt = 0;
    drive_cycle(1'b1, 4'd2, 1'b1, 2'd2);
    for (int i = 0; i < 15; i++) begin
      total++;
      if ({out0, busy0, done0} !== exp0()) begin
        bad++; $display("[TB] FAIL hsv_seq[%0d] d0 got=%b exp=%b", i, {out0, busy0, done0}, exp0());
      end
      total++;
      if ({out1, busy1, done1} !== exp1()) begin
        bad++; $display("[TB] FAIL hsv_seq[%0d] d1 got=%b exp=%b", i, {out1, busy1, done1}, exp1());
      end
      busy_cnt += int'(busy0);
      done_cnt += int'(done0);
      drive_cycle(1'b0, 4'd0, 1'b1, 2'd1);
    end
    total++;
    if (busy_cnt !== 12) begin
      bad++; $display("[TB] FAIL hsv_busy_len got=%0d exp=12", busy_cnt);
    end
    total++;
    if (done_cnt !== 1) begin
      bad++; $display("[TB] FAIL hsv_done_count got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_abort_last();
    drive_cycle(1'b1, 4'd2, 1'b0, 2'd0);
    for (int i = 0; i < 11; i++) drive_cycle(1'b0, 4'd0, 1'b0, 2'd0);
    total++;
    if (out0 !== 4'd6) begin
      bad++; $display("[TB] FAIL abort_pre_v got=%0d exp=6", out0);
    end
    drive_cycle(1'b1, 4'd3, 1'b0, 2'd0);
    total++;
    if ({out0, busy0, done0} !== {4'd2, 1'b0, !ABORT_EN}) begin
      bad++; $display("[TB] FAIL abort_last got=%b exp=%b", {out0, busy0, done0}, {4'd2, 1'b0, !ABORT_EN});
    end
    drive_cycle(1'b0, 4'd0, 1'b0, 2'd0);
    total++;
    if ({out0, busy0, done0} !== exp0()) begin
      bad++; $display("[TB] FAIL abort_after got=%b exp=%b", {out0, busy0, done0}, exp0());
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] c[5] = '{4'd1, 4'd2, 4'd1, 4'd2, 4'd1};
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, c[i], 1'b1, c[i][1:0]);
      total++;
      if ({out0, busy0, done0} !== exp0()) begin
        bad++; $display("[TB] FAIL b2b[%0d] d0 got=%b exp=%b", i, {out0, busy0, done0}, exp0());
      end
      total++;
      if ({out1, busy1, done1} !== exp1()) begin
        bad++; $display("[TB] FAIL b2b[%0d] d1 got=%b exp=%b", i, {out1, busy1, done1}, exp1());
      end
    end
    for (int i = 0; i < 14; i++) drive_cycle(1'b0, 4'd0, 1'b0, 2'd0);
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 4'd2, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 4'd0, 1'b0, 2'd0);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 model_reset();
    total++;
    if ({out0, busy0, done0} !== exp0()) begin
      bad++; $display("[TB] FAIL reset_mid got=%b exp=%b", {out0, busy0, done0}, exp0());
    end
    drive_cycle(1'b0, 4'd0, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(1'b0, 4'd0, 1'b0, 2'd0);
    total++;
    if ({out0, busy0, done0} !== 6'b0010_0_0) begin
      bad++; $display("[TB] FAIL reset_mid_release got=%b exp=%b", {out0, busy0, done0}, 6'b0010_0_0);
    end
  endtask

  task automatic test_random();
    logic       v0, v1;
    logic [3:0] i0;
    logic [1:0] i1;
    for (int n = 0; n < 400; n++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      i0 = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) i0[3:2] = 2'($urandom_range(1, 3));
      i1 = 2'($urandom_range(0, 3));
      drive_cycle(v0, i0, v1, i1);
      total++;
      if ({out0, busy0, done0} !== exp0()) begin
        bad++; $display("[TB] FAIL random[%0d] d0 got=%b exp=%b", n, {out0, busy0, done0}, exp0());
      end
      total++;
      if ({out1, busy1, done1} !== exp1()) begin
        bad++; $display("[TB] FAIL random[%0d] d1 got=%b exp=%b", n, {out1, busy1, done1}, exp1());
      end
    end
  endtask

  initial begin
    $display("[TB] start, abort feature=%0d", ABORT_EN);
    test_reset();
    test_toggle();
    test_wide_ignore();
    test_hsv_sequence();
    test_abort_last();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
